// File: rtl/fixed_point_accumulator.sv
// fixed_point_accumulator: pipelined signed vector summer with a guard-bit saturating accumulator
// and a final WIDTH reduction (saturate or wrap); two cycles from last term to Out_Valid.
module fixed_point_accumulator #(
    parameter int WIDTH    = 26,
    parameter int FRAC     = 18,
    parameter int GUARD    = 4,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Port1,
    input  logic             In_Valid,
    input  logic             In_Last,
    output logic [WIDTH-1:0] Output_syn,
    output logic             Out_Valid,
    output logic             Sat_Flag
);
    localparam int AW = WIDTH + GUARD;
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // FRAC only documents the binary point; input and output share it, so no shifting occurs.
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("FRAC must lie in [0, WIDTH)");
    end

    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;
    logic             s1_last;
    logic [AW-1:0]    acc;
    logic             sticky;
    logic [AW-1:0]    fin_sum;
    logic             fin_sticky;
    logic             fin_valid;
    logic [AW:0]      sum_ext;
    logic             ovf;
    logic [AW-1:0]    acc_next;
    logic             fits;
    logic [WIDTH-1:0] reduced;

    always_comb begin
        sum_ext  = {acc[AW-1], acc} + {{(GUARD+1){s1_data[WIDTH-1]}}, s1_data};
        ovf      = sum_ext[AW] ^ sum_ext[AW-1];
        acc_next = ovf ? (sum_ext[AW] ? ACC_MIN : ACC_MAX) : sum_ext[AW-1:0];
        fits     = (&fin_sum[AW-1:WIDTH-1]) | ~(|fin_sum[AW-1:WIDTH-1]);
        reduced  = (SATURATE != 0 && !fits) ? (fin_sum[AW-1] ? OUT_MIN : OUT_MAX) : fin_sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_data  <= Port1;
            s1_valid <= In_Valid & ~Clear;
            s1_last  <= In_Valid & In_Last;
        end
    end

    // A last term clears the accumulator in the same edge it closes the sum, so the next term starts at 0.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            acc        <= '0;
            sticky     <= 1'b0;
            fin_sum    <= '0;
            fin_sticky <= 1'b0;
            fin_valid  <= 1'b0;
        end else begin
            fin_valid <= s1_valid & s1_last & ~Clear;
            if (Clear) begin
                acc    <= '0;
                sticky <= 1'b0;
            end else if (s1_valid) begin
                acc    <= s1_last ? '0 : acc_next;
                sticky <= ~s1_last & (sticky | ovf);
                if (s1_last) begin
                    fin_sum    <= acc_next;
                    fin_sticky <= sticky | ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            Output_syn <= '0;
            Out_Valid  <= 1'b0;
            Sat_Flag   <= 1'b0;
        end else begin
            Out_Valid <= fin_valid;
            Sat_Flag  <= fin_valid & (fin_sticky | ~fits);
            if (fin_valid) Output_syn <= reduced;
        end
    end
endmodule

// File: tb/tb_fixed_point_accumulator.sv
// tb_fixed_point_accumulator: table-driven per-cycle vectors against a saturating and a wrapping
// instance, plus hand sequences for guard-bit clipping and asynchronous reset.
module tb_fixed_point_accumulator;
    localparam int W = 26;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         l;
        logic         c;
        logic         ov;
        logic [W-1:0] q;
        logic         f;
        logic [W-1:0] wq;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] din = '0;
    logic         vin = 1'b0;
    logic         lin = 1'b0;
    logic [W-1:0] q, wq;
    logic         ov, wov, f, wf;
    int           n_tests = 0;
    int           n_fail = 0;
    vec_t         tbl[$];

    always #5 clk = ~clk;

    fixed_point_accumulator #(.WIDTH(W), .FRAC(18), .GUARD(4), .SATURATE(1)) dut (
        .clk(clk), .GlobalReset(rst_n), .Clear(clr), .Port1(din), .In_Valid(vin), .In_Last(lin),
        .Output_syn(q), .Out_Valid(ov), .Sat_Flag(f)
    );

    fixed_point_accumulator #(.WIDTH(W), .FRAC(18), .GUARD(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .GlobalReset(rst_n), .Clear(clr), .Port1(din), .In_Valid(vin), .In_Last(lin),
        .Output_syn(wq), .Out_Valid(wov), .Sat_Flag(wf)
    );

    function automatic vec_t mk(logic [W-1:0] d, logic v, logic l, logic c,
                                logic ovx, logic [W-1:0] qx, logic fx, logic [W-1:0] wqx);
        vec_t r;
        r.d = d; r.v = v; r.l = l; r.c = c; r.ov = ovx; r.q = qx; r.f = fx; r.wq = wqx;
        return r;
    endfunction

    function automatic vec_t idle(logic ovx, logic [W-1:0] qx, logic fx, logic [W-1:0] wqx);
        return mk('0, 1'b0, 1'b0, 1'b0, ovx, qx, fx, wqx);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ovx, input logic [W-1:0] qx,
                             input logic fx, input logic [W-1:0] wqx);
        check({tag, " Out_Valid"}, W'(ov), W'(ovx));
        check({tag, " Output_syn"}, q, qx);
        check({tag, " Sat_Flag"}, W'(f), W'(fx));
        check({tag, " wrap Out_Valid"}, W'(wov), W'(ovx));
        check({tag, " wrap Output_syn"}, wq, wqx);
        check({tag, " wrap Sat_Flag"}, W'(wf), W'(fx));
    endtask

    task automatic step(input logic [W-1:0] d, input logic v, input logic l, input logic c);
        @(negedge clk);
        din = d; vin = v; lin = l; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single term 1.0
        tbl.push_back(mk(26'h0040000, 1, 1, 0, 0, 26'h0, 0, 26'h0));
        tbl.push_back(idle(0, 26'h0, 0, 26'h0));
        tbl.push_back(idle(1, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(idle(0, 26'h0040000, 0, 26'h0040000));
        // gapped vector 1.5 + 2.25 - 0.75 + 0.5 = 3.5
        tbl.push_back(mk(26'h0060000, 1, 0, 0, 0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(idle(0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(mk(26'h0090000, 1, 0, 0, 0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(idle(0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(mk(26'h3FD0000, 1, 0, 0, 0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(idle(0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(mk(26'h0020000, 1, 1, 0, 0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(idle(0, 26'h0040000, 0, 26'h0040000));
        tbl.push_back(idle(1, 26'h00E0000, 0, 26'h00E0000));
        // positive then negative WIDTH overflow, back to back
        tbl.push_back(mk(26'h1FFFFFF, 1, 0, 0, 0, 26'h00E0000, 0, 26'h00E0000));
        tbl.push_back(mk(26'h1FFFFFF, 1, 1, 0, 0, 26'h00E0000, 0, 26'h00E0000));
        tbl.push_back(mk(26'h2000000, 1, 0, 0, 0, 26'h00E0000, 0, 26'h00E0000));
        tbl.push_back(mk(26'h2000000, 1, 1, 0, 1, 26'h1FFFFFF, 1, 26'h3FFFFFE));
        tbl.push_back(idle(0, 26'h1FFFFFF, 0, 26'h3FFFFFE));
        tbl.push_back(idle(1, 26'h2000000, 1, 26'h0));
        tbl.push_back(idle(0, 26'h2000000, 0, 26'h0));
        // back-to-back {1.0,1.0} {-2.0}
        tbl.push_back(mk(26'h0040000, 1, 0, 0, 0, 26'h2000000, 0, 26'h0));
        tbl.push_back(mk(26'h0040000, 1, 1, 0, 0, 26'h2000000, 0, 26'h0));
        tbl.push_back(mk(26'h3F80000, 1, 1, 0, 0, 26'h2000000, 0, 26'h0));
        tbl.push_back(idle(1, 26'h0080000, 0, 26'h0080000));
        tbl.push_back(idle(1, 26'h3F80000, 0, 26'h3F80000));
        tbl.push_back(idle(0, 26'h3F80000, 0, 26'h3F80000));
        // Clear with same-cycle 4.0, then 0.5 last
        tbl.push_back(mk(26'h0040000, 1, 0, 0, 0, 26'h3F80000, 0, 26'h3F80000));
        tbl.push_back(mk(26'h0080000, 1, 0, 0, 0, 26'h3F80000, 0, 26'h3F80000));
        tbl.push_back(mk(26'h0100000, 1, 0, 1, 0, 26'h3F80000, 0, 26'h3F80000));
        tbl.push_back(mk(26'h0020000, 1, 1, 0, 0, 26'h3F80000, 0, 26'h3F80000));
        tbl.push_back(idle(0, 26'h3F80000, 0, 26'h3F80000));
        tbl.push_back(idle(1, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(0, 26'h0020000, 0, 26'h0020000));
        // Clear drops a last term already in stage 1
        tbl.push_back(mk(26'h0040000, 1, 1, 0, 0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(mk(26'h0, 0, 0, 1, 0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(0, 26'h0020000, 0, 26'h0020000));
        // In_Last without In_Valid is ignored
        tbl.push_back(mk(26'h0040000, 1, 0, 0, 0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(mk(26'h0040000, 0, 1, 0, 0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(mk(26'h0040000, 1, 1, 0, 0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(0, 26'h0020000, 0, 26'h0020000));
        tbl.push_back(idle(1, 26'h0080000, 0, 26'h0080000));
        tbl.push_back(idle(0, 26'h0080000, 0, 26'h0080000));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 26'h0, 1'b0, 26'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].c);
            check_all($sformatf("row%0d", i), tbl[i].ov, tbl[i].q, tbl[i].f, tbl[i].wq);
        end

        // 17 x max: accumulator clips at guard limit; wrap output exposes the clipped value
        for (int i = 0; i < 17; i++) step(26'h1FFFFFF, 1'b1, i == 16, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check_all("guard pre", 1'b0, 26'h0080000, 1'b0, 26'h0080000);
        step('0, 1'b0, 1'b0, 1'b0);
        check_all("guard", 1'b1, 26'h1FFFFFF, 1'b1, 26'h3FFFFFF);

        // reset mid-vector with a last term in flight
        step(26'h0040000, 1'b1, 1'b0, 1'b0);
        step(26'h0040000, 1'b1, 1'b0, 1'b0);
        step(26'h0040000, 1'b1, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 1'b0, 26'h0, 1'b0, 26'h0);
        din = '0; vin = 1'b0; lin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step('0, 1'b0, 1'b0, 1'b0);
            check_all($sformatf("post reset %0d", i), 1'b0, 26'h0, 1'b0, 26'h0);
        end

        // first term after release is accepted
        step(26'h0040000, 1'b1, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        check_all("first term pre", 1'b0, 26'h0, 1'b0, 26'h0);
        step('0, 1'b0, 1'b0, 1'b0);
        check_all("first term", 1'b1, 26'h0040000, 1'b0, 26'h0040000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_point_accumulator.md
FIXED_POINT_ACCUMULATOR -- requirements
Module: fixed_point_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 26, data word width (signed two's complement, sfixWIDTH_EnFRAC).
REQ-002 SHALL have parameter FRAC, default 18, fraction bits; informational only, since binary point alignment is identical on input and output.
REQ-003 SHALL have parameter GUARD, default 4, extra accumulator MSBs (accumulator width WIDTH+GUARD).
REQ-004 SHALL have parameter SATURATE, default 1; 1 = clip output to WIDTH range, 0 = truncate to low WIDTH bits (wrap).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port GlobalReset, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port Clear, input, 1, synchronous abort of the vector in progress.
REQ-008 SHALL have port Port1, input, WIDTH, signed input term.
REQ-009 SHALL have port In_Valid, input, 1, Port1 holds a valid term this cycle.
REQ-010 SHALL have port In_Last, input, 1, qualified by In_Valid; the term is the final one of the vector.
REQ-011 SHALL have port Output_syn, output, WIDTH, signed vector sum.
REQ-012 SHALL have port Out_Valid, output, 1, single-cycle pulse; Output_syn is new.
REQ-013 SHALL have port Sat_Flag, output, 1, valid with Out_Valid; the result was clipped or wrapped.

Function
REQ-014 Stage 1 SHALL register Port1, In_Valid and In_Last every cycle (input pipeline register).
REQ-015 Stage 2 SHALL, when stage-1 valid, add the sign-extended stage-1 term to the WIDTH+GUARD accumulator.
REQ-016 The accumulator SHALL itself saturate at the WIDTH+GUARD signed limits and set an internal sticky overflow bit on any such clip.
REQ-017 The accumulator SHALL hold its value on cycles with stage-1 valid low; gaps between terms are legal and unbounded.
REQ-018 On a stage-1 term with last set, the block SHALL load Output_syn with the final sum reduced to WIDTH per SATURATE, pulse Out_Valid for exactly 1 cycle, and clear the accumulator and sticky bit.
REQ-019 Latency SHALL be 2 cycles: a term with In_Valid & In_Last sampled at edge k gives Out_Valid high after edge k+2.
REQ-020 Sat_Flag SHALL be high with Out_Valid if the sticky bit was set or the final WIDTH reduction changed the value; it SHALL be low when Out_Valid is low.
REQ-021 With SATURATE=1, results above 2^(WIDTH-1)-1 SHALL give 2^(WIDTH-1)-1 and results below -2^(WIDTH-1) SHALL give -2^(WIDTH-1).
REQ-022 With SATURATE=0, the output SHALL be the low WIDTH bits, and Sat_Flag SHALL still report the overflow.
REQ-023 Output_syn SHALL hold its last result until the next Out_Valid.
REQ-024 Back-to-back vectors SHALL sustain full rate: the term after a last term starts a new sum from 0 in the same cycle the accumulator clears, with no bubble.
REQ-025 Clear SHALL zero the accumulator, the sticky bit and stage-1 valid at the next edge, and has priority over any same-cycle In_Valid (that term is dropped).
REQ-026 A last term already in stage 1 when Clear asserts SHALL be dropped, with no Out_Valid.
REQ-027 In_Last with In_Valid low SHALL be ignored.

Reset
REQ-028 GlobalReset low SHALL immediately clear all registers: Output_syn=0, Out_Valid=0, Sat_Flag=0, accumulator=0, stage-1 valid=0.
REQ-029 Reset release SHALL be synchronous to clk, with the first accepted term on the first edge after deassertion.
REQ-030 Reset asserted mid-vector SHALL discard the partial sum, and no Out_Valid SHALL follow.

Verification (WIDTH=26, FRAC=18, GUARD=4, SATURATE=1)
REQ-031 Reset: drive 3 terms, then GlobalReset=0 for 1 cycle -> outputs 0 asynchronously; no Out_Valid after release.
REQ-032 Single term: Port1=0x0040000 (1.0), In_Valid=In_Last=1 at edge k -> Output_syn=0x0040000, Out_Valid=1 at k+2 only, Sat_Flag=0.
REQ-033 Vector with gaps: 1.5, 2.25, -0.75, 0.5 with In_Valid low between terms -> Output_syn=0x00E0000 (3.5), Sat_Flag=0.
REQ-034 Saturation: two terms 0x1FFFFFF -> Output_syn=0x1FFFFFF, Sat_Flag=1; two terms 0x2000000 -> 0x2000000, Sat_Flag=1; with SATURATE=0 the first case gives 0x3FFFFFE, Sat_Flag=1.
REQ-035 Back-to-back: vectors {1.0,1.0} and {-2.0} with no idle cycle -> Out_Valid on two consecutive-vector cycles, giving 0x0080000 then 0x3F80000.
REQ-036 Clear: terms 1.0, 2.0, Clear with a same-cycle term 4.0, then 0.5 last -> Output_syn=0x0020000 (0.5), exactly one Out_Valid.
